// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: refresh sequencer in front of the writepixels serial writer.
// Holds a 16-byte frame buffer and, per refresh, issues one display-control
// command (pos 0xFF), waits a settle pause, then streams bytes to 0xC0..0xCF.
// Optional feature macro: LED_SCHED_AUTOREFRESH_EN (periodic refresh tick).
// The immediate-refresh request input is named force_req because `force`
// is a reserved word in SystemVerilog.
module led_frame_scheduler #(
    parameter int unsigned CLK_HZ       = 12_000_000,
    parameter int unsigned REFRESH_HZ   = 1,
    parameter int unsigned PAUSE_CYCLES = 1200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       disp_on,
    input  logic [2:0] bright,
    input  logic       force_req,
    input  logic       px_busy,
    output logic       px_valid,
    output logic [7:0] px_pos,
    output logic [7:0] px_value,
    output logic       frame_done,
    output logic [1:0] state_dbg
);

    localparam int unsigned FB_DEPTH = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned PAUSE_W  = $clog2(PAUSE_CYCLES + 1);

    localparam logic [PAUSE_W-1:0] PAUSE_LAST  = PAUSE_W'(PAUSE_CYCLES - 1);
    localparam logic [BYTE_W-1:0]  CTRL_POS    = 8'hFF;
    localparam logic [BYTE_W-1:0]  CTRL_OFF    = 8'h80;
    localparam logic [4:0]         CTRL_ON_HI  = 5'b10001;
    localparam logic [3:0]         DATA_POS_HI = 4'hC;

    // A zero pause or a refresh rate above the clock rate has no meaningful hardware
    if (PAUSE_CYCLES == 0 || REFRESH_HZ == 0 || CLK_HZ < REFRESH_HZ) begin : g_bad_param
        $error("led_frame_scheduler: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CTRL  = 2'd1,
        PAUSE = 2'd2,
        DATA  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [PAUSE_W-1:0]  pause_cnt, pause_cnt_d;
    logic                dirty, dirty_d;
    logic                force_pend, force_pend_d;
    logic                tick_pend, tick_pend_d;
    logic                px_valid_d;
    logic [BYTE_W-1:0]   px_pos_d, px_value_d;
    logic                frame_done_d;
    logic                issue_ok_c;
    logic                tick_c;
    logic [BYTE_W-1:0]   fb [FB_DEPTH];

`ifdef LED_SCHED_AUTOREFRESH_EN
    localparam logic [31:0] TICK_LAST = 32'(CLK_HZ / REFRESH_HZ - 1);
    logic [31:0] tick_cnt;

    // Free-running refresh period counter; tick_c marks the wrap cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    assign tick_c = (tick_cnt == TICK_LAST);
`else
    assign tick_c = 1'b0;
`endif

    // The writer takes a new byte only when idle and our last strobe has been seen
    assign issue_ok_c = !px_busy && !px_valid;
    assign state_dbg  = state;

    // Frame buffer: upstream writes land on any cycle, independent of the read index
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FB_DEPTH; i++) begin
                fb[i] <= '0;
            end
        end else if (wr_en) begin
            fb[wr_addr] <= wr_data;
        end
    end

    // State, pending flags and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            idx        <= '0;
            pause_cnt  <= '0;
            dirty      <= 1'b1;
            force_pend <= 1'b0;
            tick_pend  <= 1'b0;
            px_valid   <= 1'b0;
            px_pos     <= '0;
            px_value   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            pause_cnt  <= pause_cnt_d;
            dirty      <= dirty_d;
            force_pend <= force_pend_d;
            tick_pend  <= tick_pend_d;
            px_valid   <= px_valid_d;
            px_pos     <= px_pos_d;
            px_value   <= px_value_d;
            frame_done <= frame_done_d;
        end
    end

    // Next-state and output decode; new requests arriving while a frame is
    // being launched survive the flag clear so they produce a follow-up frame
    always_comb begin
        state_d      = state;
        idx_d        = idx;
        pause_cnt_d  = pause_cnt;
        dirty_d      = dirty | wr_en;
        force_pend_d = force_pend | force_req;
        tick_pend_d  = tick_pend | tick_c;
        px_valid_d   = 1'b0;
        px_pos_d     = px_pos;
        px_value_d   = px_value;
        frame_done_d = 1'b0;

        case (state)
            IDLE: begin
                if (dirty || force_pend || tick_pend) begin
                    state_d      = CTRL;
                    dirty_d      = wr_en;
                    force_pend_d = force_req;
                    tick_pend_d  = tick_c;
                end
            end
            CTRL: begin
                if (issue_ok_c) begin
                    px_valid_d  = 1'b1;
                    px_pos_d    = CTRL_POS;
                    px_value_d  = disp_on ? {CTRL_ON_HI, bright} : CTRL_OFF;
                    pause_cnt_d = '0;
                    state_d     = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_cnt == PAUSE_LAST) begin
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    pause_cnt_d = pause_cnt + PAUSE_W'(1);
                end
            end
            DATA: begin
                if (issue_ok_c) begin
                    px_valid_d = 1'b1;
                    px_pos_d   = {DATA_POS_HI, idx};
                    px_value_d = fb[idx];
                    idx_d      = idx + IDX_W'(1);
                    if (idx == IDX_W'(FB_DEPTH - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: busy-holding writer model, a frame-level
// reference (shadow frame buffer + expected command/address stream) checked on
// every issue strobe, directed scenarios and a randomized write/force phase.
module tb_led_frame_scheduler;

    localparam int unsigned CLK_HZ     = 1000;
    localparam int unsigned REFRESH_HZ = 1;
    localparam int unsigned PAUSE_CYC  = 40;
    localparam int          BUSY_HOLD  = 20;
    localparam int          PERIOD     = CLK_HZ / REFRESH_HZ;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       disp_on = 1'b1;
    logic [2:0] bright = 3'd7;
    logic       force_req = 1'b0;
    logic       px_busy;
    logic       px_valid;
    logic [7:0] px_pos;
    logic [7:0] px_value;
    logic       frame_done;
    logic [1:0] state_dbg;

    led_frame_scheduler #(
        .CLK_HZ      (CLK_HZ),
        .REFRESH_HZ  (REFRESH_HZ),
        .PAUSE_CYCLES(PAUSE_CYC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .disp_on   (disp_on),
        .bright    (bright),
        .force_req (force_req),
        .px_busy   (px_busy),
        .px_valid  (px_valid),
        .px_pos    (px_pos),
        .px_value  (px_value),
        .frame_done(frame_done),
        .state_dbg (state_dbg)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Writer model: busy for BUSY_HOLD cycles after each accepted strobe
    int busy_cnt = 0;
    always @(posedge CLK) begin
        if (px_valid) busy_cnt <= BUSY_HOLD;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign px_busy = (busy_cnt != 0);

    // Shadow frame buffer; snapshots hold what an issue in the cycle just ended must carry
    logic [7:0] m_fb [16];
    logic [7:0] snap_fb [16];
    logic [7:0] snap_ctrl;
    initial for (int i = 0; i < 16; i++) m_fb[i] = 8'h00;

    always @(posedge CLK) begin
        snap_fb   = m_fb;
        snap_ctrl = disp_on ? (8'h88 + 8'(bright)) : 8'h80;
        if (RST) begin
            for (int i = 0; i < 16; i++) m_fb[i] = 8'h00;
        end else if (wr_en) begin
            m_fb[wr_addr] = wr_data;
        end
    end

    // Stream tracker: k = 0 expects the control command, 1..16 expect data bytes
    int         cyc = 0;
    int         k = 0;
    int         frames = 0;
    int         ctrl_cyc = -1000;
    int         last_valid_cyc = -1000;
    logic [7:0] last_ctrl = '0;
    logic [7:0] cur_frame [16];
    logic [7:0] last_frame [16];
    logic [7:0] prev_frame [16];

    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            k = 0;
            chk("rst_valid", int'(px_valid), 0);
            chk("rst_pos", int'(px_pos), 0);
            chk("rst_value", int'(px_value), 0);
            chk("rst_done", int'(frame_done), 0);
            chk("rst_state", int'(state_dbg), 0);
        end else begin
            chk("done_pulse", int'(frame_done), int'(px_valid && px_pos == 8'hCF));
            if (px_valid) begin
                chk("busy_guard", int'(px_busy), 0);
                chk("issue_spacing", int'(cyc - last_valid_cyc >= 2), 1);
                last_valid_cyc = cyc;
                if (k == 0) begin
                    chk("ctrl_pos", int'(px_pos), 8'hFF);
                    chk("ctrl_value", int'(px_value), int'(snap_ctrl));
                    chk("state_after_ctrl", int'(state_dbg), 2);
                    last_ctrl = px_value;
                    ctrl_cyc  = cyc;
                    k = 1;
                end else begin
                    chk("data_pos", int'(px_pos), 8'hC0 + k - 1);
                    chk("data_value", int'(px_value), int'(snap_fb[k-1]));
                    if (k == 1) chk("pause_len", int'(cyc - ctrl_cyc >= int'(PAUSE_CYC)), 1);
                    chk("state_after_data", int'(state_dbg), (k == 16) ? 0 : 3);
                    cur_frame[k-1] = px_value;
                    if (k == 16) begin
                        prev_frame = last_frame;
                        last_frame = cur_frame;
                        frames++;
                        k = 0;
                    end else begin
                        k++;
                    end
                end
            end
        end
    end

    // Under periodic refresh extra tick frames may appear, so counts become lower bounds
    task automatic chk_frames(input string nm, input int got, input int want);
`ifdef LED_SCHED_AUTOREFRESH_EN
        chk(nm, int'(got >= want), 1);
`else
        chk(nm, got, want);
`endif
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 100 && n < 6000) begin
            @(negedge CLK);
            n++;
            if (state_dbg == 2'd0 && !px_busy && !RST) quiet++;
            else quiet = 0;
        end
        chk("idle_reached", int'(quiet >= 100), 1);
    endtask

    task automatic wait_state(input logic [1:0] s, input string nm);
        int n = 0;
        while (state_dbg !== s && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, int'(state_dbg === s), 1);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk("frame_arrived", int'(frames >= target), 1);
    endtask

    task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
        @(posedge CLK); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge CLK); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_force();
        @(posedge CLK); #1 force_req = 1'b1;
        @(posedge CLK); #1 force_req = 1'b0;
    endtask

    int f0;
    int c1, c2, c3;
    int n;

    initial begin
        // Reset state, then the power-up frame triggered by the reset value of dirty
        repeat (3) @(negedge CLK);
        @(posedge CLK); #1 RST = 1'b0;
        f0 = frames;
        wait_idle();
        chk_frames("reset_frame_count", frames - f0, 1);
        chk("reset_ctrl_8F", int'(last_ctrl), 8'h8F);
        for (int i = 0; i < 16; i++) chk("reset_frame_zero", int'(last_frame[i]), 0);

        // Idle write: trigger-to-CTRL latency, display-off control value
        disp_on = 1'b0;
        f0 = frames;
        write_byte(4'd5, 8'hA5);
        @(negedge CLK);
        chk("idle_before_trigger", int'(state_dbg), 0);
        @(negedge CLK);
        chk("trigger_to_ctrl", int'(state_dbg), 1);
        wait_idle();
        chk_frames("write_frame_count", frames - f0, 1);
        chk("ctrl_off_80", int'(last_ctrl), 8'h80);
        chk("c5_a5", int'(last_frame[5]), 8'hA5);

        // Write during PAUSE: lands in this frame and forces one more
        disp_on = 1'b1;
        bright  = 3'($urandom_range(0, 7));
        f0 = frames;
        pulse_force();
        wait_state(2'd2, "reach_pause");
        write_byte(4'd10, 8'h3C);
        wait_idle();
        chk_frames("pause_write_frames", frames - f0, 2);
        chk("ca_first_frame", int'(prev_frame[10]), 8'h3C);
        chk("ca_second_frame", int'(last_frame[10]), 8'h3C);

        // Force during DATA: frame completes, exactly one extra follows
        f0 = frames;
        pulse_force();
        wait_state(2'd3, "reach_data");
        pulse_force();
        wait_idle();
        chk_frames("force_mid_data_frames", frames - f0, 2);

        // Reset at data byte 7: outputs clear immediately, a full frame restarts
        pulse_force();
        n = 0;
        while (!(px_valid && px_pos == 8'hC7) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk("reach_c7", int'(px_valid && px_pos == 8'hC7), 1);
        #2 RST = 1'b1;
        #1;
        chk("abort_valid", int'(px_valid), 0);
        chk("abort_pos", int'(px_pos), 0);
        chk("abort_value", int'(px_value), 0);
        chk("abort_state", int'(state_dbg), 0);
        @(posedge CLK);
        @(posedge CLK); #1 RST = 1'b0;
        f0 = frames;
        wait_idle();
        chk_frames("restart_frames", frames - f0, 1);
        chk("restart_c5_cleared", int'(last_frame[5]), 0);
        chk("restart_ca_cleared", int'(last_frame[10]), 0);

        // Randomized writes, forces and control changes against the shadow buffer
        for (int i = 0; i < 8000; i++) begin
            @(posedge CLK); #1;
            wr_en     = ($urandom_range(0, 39) == 0);
            wr_addr   = 4'($urandom);
            wr_data   = 8'($urandom);
            force_req = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) begin
                disp_on = 1'($urandom);
                bright  = 3'($urandom);
            end
        end
        @(posedge CLK); #1;
        wr_en = 1'b0;
        force_req = 1'b0;
        wait_idle();
        for (int i = 0; i < 16; i++) chk("final_frame_matches_buffer", int'(last_frame[i]), int'(m_fb[i]));

`ifdef LED_SCHED_AUTOREFRESH_EN
        // Periodic refresh with no writes: control commands exactly one period apart
        wait_frames(frames + 1);
        c1 = ctrl_cyc;
        wait_frames(frames + 1);
        c2 = ctrl_cyc;
        wait_frames(frames + 1);
        c3 = ctrl_cyc;
        chk("refresh_period_1", c2 - c1, PERIOD);
        chk("refresh_period_2", c3 - c2, PERIOD);
`else
        // No refresh tick: the block must stay idle with nothing pending
        f0 = frames;
        repeat (3000) @(negedge CLK);
        chk("no_spontaneous_frame", frames - f0, 0);
        chk("stays_idle", int'(state_dbg), 0);
        c1 = 0; c2 = 0; c3 = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
